wishbone_rr_arbiter: RTL

Round-robin arbiter that lets NUM_MASTERS Wishbone masters share the single register-file slave (4-bit adr, 32-bit data).
It sits between the masters and the slave, and muxes the granted master's adr, dat_mosi, we, cyc and stb onto the slave port.
It routes the slave's ack back to the granted master only, and broadcasts dat_miso to all masters.
A grant is held for the whole Wishbone cycle (cyc high), so multi-beat bursts are never interleaved.

---
 rtl/wishbone_rr_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/wishbone_rr_arbiter.sv
// wishbone_rr_arbiter: round-robin arbiter sharing one Wishbone slave
// (4-bit adr, 32-bit data) among NUM_MASTERS masters. The grant is held
// for a whole cyc, with one IDLE cycle between consecutive grants.
// Optional build macro WB_ARB_TIMEOUT_EN adds a stall watchdog that
// errors out and releases a master whose slave stops acknowledging.

// Per-master lane: gates one master's request onto the shared bus and
// steers the slave ack back to it only while it is selected.
module wishbone_rr_arbiter_lane (
    input  logic        sel,
    input  logic [3:0]  adr,
    input  logic [31:0] dat,
    input  logic        we,
    input  logic        cyc,
    input  logic        stb,
    input  logic        s_ack,
    output logic [3:0]  adr_g,
    output logic [31:0] dat_g,
    output logic        we_g,
    output logic        cyc_g,
    output logic        stb_g,
    output logic        ack
);

    // AND-gate the request so the top can OR all lanes together
    always_comb begin
        adr_g = sel ? adr : 4'h0;
        dat_g = sel ? dat : 32'h0;
        we_g  = sel & we;
        cyc_g = sel & cyc;
        stb_g = sel & stb;
        ack   = sel & s_ack;
    end

endmodule

module wishbone_rr_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int IDX_W          = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_MASTERS*4-1:0]  m_adr,
    input  logic [NUM_MASTERS*32-1:0] m_dat_mosi,
    input  logic [NUM_MASTERS-1:0]    m_we,
    input  logic [NUM_MASTERS-1:0]    m_cyc,
    input  logic [NUM_MASTERS-1:0]    m_stb,
    output logic [NUM_MASTERS-1:0]    m_ack,
    output logic [NUM_MASTERS-1:0]    m_err,
    output logic [31:0]               m_dat_miso,
    output logic [3:0]                s_adr,
    output logic [31:0]               s_dat_mosi,
    output logic                      s_we,
    output logic                      s_cyc,
    output logic                      s_stb,
    input  logic                      s_ack,
    input  logic [31:0]               s_dat_miso,
    output logic                      grant_valid,
    output logic [IDX_W-1:0]          grant_idx
);

    typedef enum logic {IDLE, OWN} state_t;

    localparam logic [IDX_W:0]   NM     = (IDX_W+1)'(NUM_MASTERS);
    localparam logic [IDX_W-1:0] LAST_R = IDX_W'(NUM_MASTERS-1);

    state_t                          state_q, state_d;
    logic [IDX_W-1:0]                grant_q, grant_d;
    logic [IDX_W-1:0]                last_q, last_d;
    logic [IDX_W-1:0]                winner;
    logic [IDX_W:0]                  scan;
    logic                            found;
    logic                            tmo_hit;
    logic [NUM_MASTERS-1:0]          sel;
    logic [NUM_MASTERS-1:0][3:0]     adr_g;
    logic [NUM_MASTERS-1:0][31:0]    dat_g;
    logic [NUM_MASTERS-1:0]          we_g, cyc_g, stb_g;

    // Round-robin pick: first requester after last_q, wrapping modulo NUM_MASTERS
    always_comb begin
        winner = last_q;
        found  = 1'b0;
        scan   = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            scan = {1'b0, last_q} + (IDX_W+1)'(k);
            if (scan >= NM) scan = scan - NM;
            if (!found && m_cyc[scan[IDX_W-1:0]]) begin
                winner = scan[IDX_W-1:0];
                found  = 1'b1;
            end
        end
    end

    // Grant FSM next state: arbitrate only from IDLE, release when owner drops cyc
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (|m_cyc) begin
                    state_d = OWN;
                    grant_d = winner;
                    last_d  = winner;
                end
            end
            OWN: begin
                if (!m_cyc[grant_q] || tmo_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant state registers; reset makes master 0 the first winner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_R;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign grant_valid = (state_q == OWN);
    assign grant_idx   = grant_q;
    assign m_dat_miso  = s_dat_miso;

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_lane
        assign sel[i] = (state_q == OWN) && (grant_q == IDX_W'(i));
        wishbone_rr_arbiter_lane u_lane (
            .sel   (sel[i]),
            .adr   (m_adr[4*i +: 4]),
            .dat   (m_dat_mosi[32*i +: 32]),
            .we    (m_we[i]),
            .cyc   (m_cyc[i]),
            .stb   (m_stb[i]),
            .s_ack (s_ack),
            .adr_g (adr_g[i]),
            .dat_g (dat_g[i]),
            .we_g  (we_g[i]),
            .cyc_g (cyc_g[i]),
            .stb_g (stb_g[i]),
            .ack   (m_ack[i])
        );
    end

    // At most one lane is non-zero, so OR-ing the gated lanes forms the mux
    always_comb begin
        s_adr      = '0;
        s_dat_mosi = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            s_adr      = s_adr | adr_g[i];
            s_dat_mosi = s_dat_mosi | dat_g[i];
        end
        s_we  = |we_g;
        s_cyc = |cyc_g;
        s_stb = |stb_g;
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    assign tmo_hit = (state_q == OWN) && (tmo_cnt == 8'(TIMEOUT_CYCLES));
    assign m_err   = sel & {NUM_MASTERS{tmo_hit}};

    // Stall counter: counts unacknowledged strobe cycles of the current owner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= 8'h0;
        end else if (state_q != OWN || state_d != OWN || s_ack) begin
            tmo_cnt <= 8'h0;
        end else if (s_stb && !tmo_hit) begin
            tmo_cnt <= tmo_cnt + 8'h1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign m_err   = '0;
`endif

endmodule
